hdc_class_trainer: RTL and testbench
====================================

# hdc_class_trainer

Trainer for the HDC spam classifier's associative memory. It streams bipolar message hypervectors, each tagged with a ham/spam label, into per-dimension saturating class accumulators. On command it streams out the binarized class hypervectors. This is the writer side of the ham/spam reference vectors that the classifier reads.

## Interface
- DIM, 10000, hypervector dimensions; must be a multiple of W, with DIM/W >= 2
- W, 16, dimensions per beat (in and out)
- ACC_BITS, 12, signed accumulator width per class per dimension
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  W  bit i is dimension beat*W+i; 1 means +1, 0 means -1
- in_label  input  2  0=ham, 1=spam, 2/3=invalid; sampled on first beat of each message
- clear  input  1  pulse: zero all accumulators and counts
- rd_start  input  1  pulse: begin readout of both class vectors
- out_valid  output  1  readout beat valid
- out_ready  input  1  readout beat consumed when out_valid & out_ready
- out_data  output  W  binarized class bits for dimensions beat*W .. beat*W+W-1
- out_class  output  1  0=ham beat, 1=spam beat
- out_last  output  1  final beat of the current class
- busy  output  1  high in CLEAR or READ
- err_label  output  1  one-cycle pulse on first beat of a message with in_label >= 2
- ham_count, spam_count  output  16 each  trained message counts, saturating at 65535

## Operation
- States: IDLE, TRAIN, CLEAR, READ.
- **IDLE:**
  - Command priority is clear > rd_start > in_valid.
  - If clear or rd_start is high, in_ready is low in that cycle.
  - An accepted beat enters TRAIN with beat index 1 and latches the label.
- **TRAIN:**
  - in_ready=1; one beat per cycle; a beat index counts 0..DIM/W-1.
  - For a valid label, each dimension d updates acc[label][d] += (bit ? +1 : -1).
  - Accumulators saturate to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
  - An invalid label means beats are accepted and discarded, with no accumulator or count change.
  - The last beat (index DIM/W-1) returns the block to IDLE.
  - The matching count increments (saturating) when the last beat of a valid-label message is accepted.
  - clear and rd_start are ignored in TRAIN.
- **CLEAR:**
  - Zeroes one W-wide row per cycle for both classes: DIM/W cycles, then IDLE.
  - ham_count and spam_count go to 0 on entry.
  - in_ready=0 during CLEAR.
- **READ:**
  - Emits DIM/W ham beats (out_class=0), then DIM/W spam beats (out_class=1).
  - out_last is set on beat DIM/W-1 of each class.
  - Output bit = 1 if acc >= 0, else 0. An all-zero accumulator therefore reads as all ones.
  - Returns to IDLE after the final spam beat is consumed.
  - in_ready=0 during READ, and commands are ignored.
- Readout reflects every message whose last beat was accepted before rd_start was sampled, including a last beat accepted the immediately preceding cycle.

## Timing
- **Reset:**
  - During reset, all outputs are 0: in_ready, out_valid, out_data, out_class, out_last, busy, err_label, ham_count, spam_count. State is CLEAR with the row counter at 0.
  - After deassertion, the block runs an automatic CLEAR: busy=1 for DIM/W cycles, then IDLE.
  - Reset mid-message or mid-readout discards the partial message or readout, then behaves as above.
- in_ready is combinational from state and the clear/rd_start inputs only; it never depends on in_valid.
- out_valid rises exactly 2 cycles after the edge that samples rd_start.
- While out_valid=1 and out_ready=0, out_data, out_class and out_last hold stable.
- With out_ready held at 1, beats are back-to-back: a full readout takes 2*DIM/W cycles after first out_valid.
- err_label pulses in the cycle after the invalid first beat is accepted.
- Counts update in the cycle after the last beat is accepted.
- No reset-induced clearing happens outside the automatic CLEAR. Accumulator storage may be RAM with synchronous read.

## Test plan
Unless stated otherwise, scenarios use DIM=64, W=16 (4 beats per message) and ACC_BITS=12.
- **Reset and empty readout:** release reset. Required: busy=1 for exactly 4 cycles, then in_ready=1. A following rd_start gives 8 beats of 0xFFFF, out_last on beats 4 and 8, and out_class 0,0,0,0,1,1,1,1.
- **Single ham message:** 4 beats of 0x0000, label 0, then rd_start. Required: ham beats all 0x0000, spam beats all 0xFFFF, ham_count=1, spam_count=0.
- **Majority and tie:**
  - Spam messages 0x00FF, 0x00FF, 0xFF00 on every beat read out 0x00FF.
  - After clear, spam messages 0xFFFF then 0x0000 leave acc=0 and read out 0xFFFF.
- **Saturation (ACC_BITS=3):** 6 ham messages of 0x0000, then 4 of 0xFFFF. Required: acc saturates at -4 and ends at 0, so readout is 0xFFFF (not 0x0000); ham_count=10.
- **Invalid label and ignored commands:**
  - A message with label 2 gives an err_label pulse, no count change and an unchanged readout.
  - rd_start asserted mid-message and clear asserted during READ have no effect.
- **Back-pressure:** toggle out_ready randomly during readout. Required: out_data/out_class/out_last stable while stalled, exactly 8 beats consumed, correct order.
- **Simultaneous commands:** clear, rd_start and in_valid high together in IDLE. Required: CLEAR runs, in_ready=0 that cycle, and there is no readout.

Source files
------------

// File: rtl/hdc_class_trainer.sv
// hdc_class_trainer: streams labelled bipolar message hypervectors into
// saturating per-class accumulators and reads back the binarized ham/spam
// class hypervectors, one W-wide row per beat.
module hdc_class_trainer #(
  parameter int DIM      = 10000,
  parameter int W        = 16,
  parameter int ACC_BITS = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [1:0]    in_label,
  input  logic          clear,
  input  logic          rd_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_class,
  output logic          out_last,
  output logic          busy,
  output logic          err_label,
  output logic [15:0]   ham_count,
  output logic [15:0]   spam_count
);

  localparam int ROWS = DIM / W;
  localparam int RW   = $clog2(ROWS);
  localparam logic [RW-1:0]       LAST_ROW = RW'(ROWS - 1);
  localparam logic [ACC_BITS-1:0] ACC_MAX  = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN  = {1'b1, {(ACC_BITS-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_CLEAR, S_READ} state_t;

  state_t              r_state;
  logic [RW-1:0]       r_row;
  logic                r_cls;
  logic                r_rd_wait;
  logic [1:0]          r_label;
  logic                r_out_valid;
  logic [W-1:0]        r_out_data;
  logic                r_out_cls;
  logic                r_out_last;
  logic                r_err;
  logic [15:0]         r_ham_cnt;
  logic [15:0]         r_spam_cnt;
  logic [ACC_BITS-1:0] r_acc [2][ROWS][W];

  logic                w_in_ready;
  logic                w_accept;
  logic [1:0]          w_lbl;
  logic                w_cls;
  logic [RW-1:0]       w_row;
  logic                w_we;
  logic                w_last_beat;
  logic [ACC_BITS-1:0] w_upd [W];
  logic [W-1:0]        w_rd_bits;

  // Input handshake: commands pending in IDLE take priority over a beat
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = ~clear & ~rd_start;
      S_TRAIN: w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign in_ready    = w_in_ready;
  assign w_accept    = in_valid & w_in_ready;
  // The first beat is accepted in IDLE, so its label comes straight from the port
  assign w_lbl       = (r_state == S_IDLE) ? in_label : r_label;
  assign w_row       = (r_state == S_IDLE) ? '0 : r_row;
  assign w_cls       = w_lbl[0];
  assign w_we        = w_accept & ~w_lbl[1];
  assign w_last_beat = (r_state == S_TRAIN) && (r_row == LAST_ROW);

  // Saturating +1/-1 update of the addressed accumulator row
  always_comb begin
    for (int unsigned i = 0; i < W; i++) begin
      w_upd[i] = r_acc[w_cls][w_row][i];
      if (in_data[i]) begin
        if (r_acc[w_cls][w_row][i] != ACC_MAX) w_upd[i] = r_acc[w_cls][w_row][i] + ACC_BITS'(1);
      end else begin
        if (r_acc[w_cls][w_row][i] != ACC_MIN) w_upd[i] = r_acc[w_cls][w_row][i] - ACC_BITS'(1);
      end
    end
  end

  // Binarize the row selected by the readout pointer: non-negative reads as 1
  always_comb begin
    for (int unsigned i = 0; i < W; i++) begin
      w_rd_bits[i] = ~r_acc[r_cls][r_row][i][ACC_BITS-1];
    end
  end

  // Accumulator storage: row-wise clear or training write, no reset
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      for (int unsigned i = 0; i < W; i++) begin
        r_acc[0][r_row][i] <= '0;
        r_acc[1][r_row][i] <= '0;
      end
    end else if (w_we) begin
      for (int unsigned i = 0; i < W; i++) begin
        r_acc[w_cls][w_row][i] <= w_upd[i];
      end
    end
  end

  // Control FSM with registered readout, error and count outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_row       <= '0;
      r_cls       <= 1'b0;
      r_rd_wait   <= 1'b0;
      r_label     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cls   <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_ham_cnt   <= '0;
      r_spam_cnt  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state    <= S_CLEAR;
            r_row      <= '0;
            r_ham_cnt  <= '0;
            r_spam_cnt <= '0;
          end else if (rd_start) begin
            r_state   <= S_READ;
            r_row     <= '0;
            r_cls     <= 1'b0;
            r_rd_wait <= 1'b1;
          end else if (in_valid) begin
            r_state <= S_TRAIN;
            r_row   <= RW'(1);
            r_label <= in_label;
            r_err   <= in_label[1];
          end
        end
        S_TRAIN: begin
          if (in_valid) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_row   <= '0;
              if (!r_label[1]) begin
                if (r_label[0]) begin
                  if (r_spam_cnt != 16'hFFFF) r_spam_cnt <= r_spam_cnt + 16'd1;
                end else begin
                  if (r_ham_cnt != 16'hFFFF) r_ham_cnt <= r_ham_cnt + 16'd1;
                end
              end
            end else begin
              r_row <= r_row + RW'(1);
            end
          end
        end
        S_CLEAR: begin
          if (r_row == LAST_ROW) begin
            r_state <= S_IDLE;
            r_row   <= '0;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        S_READ: begin
          // One wait cycle, then the output register is loaded from the pointer
          // whenever it is empty or its beat is being consumed.
          if (r_rd_wait) begin
            r_rd_wait <= 1'b0;
          end else if (!r_out_valid || out_ready) begin
            if (r_out_valid && r_out_last && r_out_cls) begin
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_cls   <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= S_IDLE;
              r_row       <= '0;
              r_cls       <= 1'b0;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_rd_bits;
              r_out_cls   <= r_cls;
              r_out_last  <= (r_row == LAST_ROW);
              if (r_row == LAST_ROW) begin
                r_row <= '0;
                r_cls <= 1'b1;
              end else begin
                r_row <= r_row + RW'(1);
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = ~reset & ((r_state == S_CLEAR) | (r_state == S_READ));
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_class  = r_out_cls;
  assign out_last   = r_out_last;
  assign err_label  = r_err;
  assign ham_count  = r_ham_cnt;
  assign spam_count = r_spam_cnt;

endmodule

// File: tb/tb_hdc_class_trainer.sv
// Bench for hdc_class_trainer: two instances (ACC_BITS=12 and ACC_BITS=3)
// share one stimulus stream; an array-based reference model predicts the
// readout of each, and a negedge process checks every consumed beat.
module tb_hdc_class_trainer;
  localparam int DIM  = 64;
  localparam int W    = 16;
  localparam int ROWS = DIM / W;

  logic clk = 1'b0;
  logic reset, in_valid, clear, rd_start, out_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_label;

  logic a_in_ready, a_out_valid, a_out_class, a_out_last, a_busy, a_err;
  logic [W-1:0] a_out_data;
  logic [15:0]  a_ham, a_spam;
  logic b_in_ready, b_out_valid, b_out_class, b_out_last, b_busy, b_err;
  logic [W-1:0] b_out_data;
  logic [15:0]  b_ham, b_spam;

  hdc_class_trainer #(.DIM(DIM), .W(W), .ACC_BITS(12)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_label(in_label), .clear(clear), .rd_start(rd_start),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_class(a_out_class), .out_last(a_out_last), .busy(a_busy),
    .err_label(a_err), .ham_count(a_ham), .spam_count(a_spam));

  hdc_class_trainer #(.DIM(DIM), .W(W), .ACC_BITS(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_label(in_label), .clear(clear), .rd_start(rd_start),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_class(b_out_class), .out_last(b_out_last), .busy(b_busy),
    .err_label(b_err), .ham_count(b_ham), .spam_count(b_spam));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: [instance][class][dimension] accumulator values
  int m_acc [2][2][DIM];
  int m_hi [2];
  int m_lo [2];
  int m_ham, m_spam;

  logic [17:0] qa[$];
  logic [17:0] qb[$];
  logic [15:0] cap [2][8];
  int          ncap [2];
  logic        c_pv [2];
  logic        c_pr [2];
  logic [17:0] c_pb [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_zero();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 2; k++)
        for (int d = 0; d < DIM; d++) m_acc[c][k][d] = 0;
    m_ham  = 0;
    m_spam = 0;
  endfunction

  function automatic void model_msg(input logic [1:0] lbl, input logic [63:0] msg);
    int v;
    if (lbl < 2) begin
      for (int c = 0; c < 2; c++)
        for (int d = 0; d < DIM; d++) begin
          v = m_acc[c][int'(lbl)][d] + (msg[d] ? 1 : -1);
          if (v > m_hi[c]) v = m_hi[c];
          if (v < m_lo[c]) v = m_lo[c];
          m_acc[c][int'(lbl)][d] = v;
        end
      if (lbl == 0) begin
        if (m_ham < 65535) m_ham++;
      end else begin
        if (m_spam < 65535) m_spam++;
      end
    end
  endfunction

  function automatic void build_expect();
    logic [17:0] e;
    qa.delete();
    qb.delete();
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < ROWS; r++) begin
          e = '0;
          for (int i = 0; i < W; i++) e[i] = (m_acc[c][k][r*W+i] >= 0);
          e[16] = k[0];
          e[17] = (r == ROWS - 1);
          if (c == 0) qa.push_back(e);
          else        qb.push_back(e);
        end
  endfunction

  // Per-instance readout check: stall stability and in-order beat contents
  task automatic port_check(input int w, input logic v, input logic r, input logic [17:0] beat);
    logic [17:0] e;
    int          qs;
    if (c_pv[w] && !c_pr[w])
      check($sformatf("stall_hold_%0d", w), {45'd0, v, beat}, {45'd0, 1'b1, c_pb[w]});
    if (v && r) begin
      qs = (w == 0) ? qa.size() : qb.size();
      if (qs == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_beat_%0d: got beat 0x%0h, expected no beat", w, beat);
      end else begin
        e = (w == 0) ? qa.pop_front() : qb.pop_front();
        check($sformatf("beat_%0d", w), {46'd0, beat}, {46'd0, e});
        if (ncap[w] < 8) begin
          cap[w][ncap[w]] = beat[15:0];
          ncap[w]++;
        end
      end
    end
    c_pv[w] = v;
    c_pr[w] = r;
    c_pb[w] = beat;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      c_pv[0] = 1'b0;
      c_pv[1] = 1'b0;
    end else begin
      port_check(0, a_out_valid, out_ready, {a_out_last, a_out_class, a_out_data});
      port_check(1, b_out_valid, out_ready, {b_out_last, b_out_class, b_out_data});
    end
  end

  task automatic busy_window(input string name);
    int n = 0;
    @(negedge clk);
    while (a_busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, n, 4);
    check({name, "_busy_b"}, b_busy, 0);
    check({name, "_in_ready_a"}, a_in_ready, 1);
    check({name, "_in_ready_b"}, b_in_ready, 1);
    check({name, "_counts"}, {a_ham, a_spam, b_ham, b_spam}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; rd_start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs_a", {a_in_ready, a_out_valid, a_out_data, a_out_class, a_out_last,
                              a_busy, a_err, a_ham, a_spam}, 64'd0);
    check("reset_outputs_b", {b_in_ready, b_out_valid, b_out_data, b_out_class, b_out_last,
                              b_busy, b_err, b_ham, b_spam}, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    qa.delete();
    qb.delete();
    model_zero();
    busy_window("reset");
  endtask

  task automatic do_clear(input bit simul);
    @(posedge clk); #1;
    clear = 1'b1;
    if (simul) begin
      rd_start = 1'b1; in_valid = 1'b1; in_data = 16'($urandom); in_label = 2'd0;
    end
    @(negedge clk);
    check("clear_in_ready_a", a_in_ready, 0);
    check("clear_in_ready_b", b_in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; rd_start = 1'b0; in_valid = 1'b0;
    model_zero();
    busy_window("clear");
    check("clear_no_readout", a_out_valid, 0);
  endtask

  task automatic send_msg(input logic [1:0] lbl, input logic [63:0] msg, input bit gaps, input bit midcmd);
    for (int b = 0; b < ROWS; b++) begin
      if (b == 0) begin
        @(posedge clk); #1;
      end
      if (gaps && b > 0) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = msg[b*W +: W];
      in_label = (b == 0) ? lbl : 2'($urandom);
      rd_start = midcmd && (b == 1);
      clear    = midcmd && (b == 2);
      @(negedge clk);
      check("train_in_ready_a", a_in_ready, 1);
      check("train_in_ready_b", b_in_ready, 1);
      if (b == ROWS - 1) check("count_before_last", {a_ham, a_spam}, {16'(m_ham), 16'(m_spam)});
      @(posedge clk); #1;
      rd_start = 1'b0;
      clear    = 1'b0;
      if (b == 0) begin
        check("err_pulse_a", a_err, (lbl >= 2));
        check("err_pulse_b", b_err, (lbl >= 2));
      end
      if (b == 1) check("err_width", a_err, 0);
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    model_msg(lbl, msg);
    check("counts_a", {a_ham, a_spam}, {16'(m_ham), 16'(m_spam)});
    check("counts_b", {b_ham, b_spam}, {16'(m_ham), 16'(m_spam)});
  endtask

  task automatic do_read(input bit bp, input bit inj_clr);
    int cyc;
    @(posedge clk); #1;
    build_expect();
    ncap[0] = 0;
    ncap[1] = 0;
    rd_start  = 1'b1;
    out_ready = bp ? 1'($urandom) : 1'b1;
    @(negedge clk);
    check("rd_in_ready_a", a_in_ready, 0);
    check("rd_in_ready_b", b_in_ready, 0);
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(negedge clk);
    check("latency_c0", a_out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("latency_c1", a_out_valid, 0);
    @(posedge clk); #1;
    out_ready = bp ? 1'($urandom) : 1'b1;
    @(negedge clk);
    check("latency_c2_a", a_out_valid, 1);
    check("latency_c2_b", b_out_valid, 1);
    cyc = 0;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < 200) begin
      @(posedge clk); #1;
      if (qa.size() != 0) check("read_in_ready", a_in_ready, 0);
      out_ready = bp ? 1'($urandom) : 1'b1;
      clear     = inj_clr && (cyc == 3);
      cyc++;
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL read_timeout: got %0d/%0d beats left, expected 0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    check("read_done_valid", {a_out_valid, b_out_valid}, 0);
    check("read_done_busy", {a_busy, b_busy}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] lbl;
    m_hi[0] = 2047; m_lo[0] = -2048;
    m_hi[1] = 3;    m_lo[1] = -4;
    in_data = '0; in_label = '0;
    model_zero();

    // reset and empty readout
    do_reset();
    do_read(0, 0);
    check("pin_empty_first", cap[0][0], 16'hFFFF);
    check("pin_empty_last", cap[0][7], 16'hFFFF);

    // single ham message of all -1
    send_msg(2'd0, 64'd0, 0, 0);
    do_read(0, 0);
    check("pin_ham_zero", cap[0][0], 16'h0000);
    check("pin_spam_ones", cap[0][4], 16'hFFFF);
    check("pin_counts", {a_ham, a_spam}, {16'd1, 16'd0});

    // majority
    do_clear(0);
    send_msg(2'd1, {4{16'h00FF}}, 0, 0);
    send_msg(2'd1, {4{16'h00FF}}, 0, 0);
    send_msg(2'd1, {4{16'hFF00}}, 0, 0);
    do_read(0, 0);
    check("pin_majority_a", cap[0][4], 16'h00FF);
    check("pin_majority_b", cap[1][7], 16'h00FF);

    // tie reads as ones
    do_clear(0);
    send_msg(2'd1, {4{16'hFFFF}}, 1, 0);
    send_msg(2'd1, 64'd0, 1, 0);
    do_read(0, 0);
    check("pin_tie", cap[0][5], 16'hFFFF);

    // saturation on the 3-bit instance
    do_clear(0);
    for (int k = 0; k < 6; k++) send_msg(2'd0, 64'd0, 0, 0);
    for (int k = 0; k < 4; k++) send_msg(2'd0, {64{1'b1}}, 0, 0);
    do_read(1, 0);
    check("pin_sat_b", cap[1][0], 16'hFFFF);
    check("pin_nosat_a", cap[0][0], 16'h0000);
    check("pin_ham10", b_ham, 16'd10);

    // invalid labels, commands during TRAIN and READ
    send_msg(2'd2, {$urandom, $urandom}, 1, 0);
    send_msg(2'd3, {$urandom, $urandom}, 0, 1);
    check("pin_inv_counts", a_ham, 16'd10);
    do_read(1, 1);
    check("pin_inv_unchanged", cap[1][0], 16'hFFFF);

    // randomized traffic with back-pressure
    for (int k = 0; k < 24; k++) begin
      lbl = ($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      send_msg(lbl, {$urandom, $urandom}, 1, (k % 5) == 2);
      if (k % 8 == 7) do_read(1, k == 15);
    end

    // simultaneous clear, rd_start and beat
    do_clear(1);
    do_read(1, 0);
    check("pin_after_simul", cap[0][0], 16'hFFFF);

    // reset in the middle of a message
    send_msg(2'd1, {$urandom, $urandom}, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h0000; in_label = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    do_read(0, 0);
    check("pin_after_reset", cap[0][3], 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
